// File: rtl/tm_serial_loader_pkg.sv
// Shared types for the serial loader: command opcodes, FSM state encodings and
// command-byte field helpers.
package tm_loader_pkg;

  localparam int CMD_VALUE_W = 6;

  typedef enum logic [1:0] {
    OP_DATA = 2'b00,
    OP_DONE = 2'b01,
    OP_STEP = 2'b10,
    OP_RSVD = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SETUP = 2'd1,
    SEQ_PULSE = 2'd2,
    SEQ_GAP   = 2'd3
  } seq_state_t;

  function automatic opcode_t cmd_opcode(input logic [7:0] cmd);
    return opcode_t'(cmd[7:6]);
  endfunction

  function automatic logic [CMD_VALUE_W-1:0] cmd_value(input logic [7:0] cmd);
    return cmd[CMD_VALUE_W-1:0];
  endfunction

endpackage

// File: rtl/tm_serial_loader_if.sv
// Button-protocol bus between the loader (master) and the Turing machine core (slave).
interface tm_serial_loader_if #(parameter int AW = 6) ();
  logic [AW-1:0] input_data;
  logic          Next;
  logic          Done;

  modport master (output input_data, output Next, output Done);
  modport slave  (input  input_data, input  Next, input  Done);
endinterface

// File: rtl/tm_serial_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte_valid,
// and a one-cycle frame_err_pulse when the stop bit is sampled low.
module uart_rx_8n1
  import tm_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TW       = $clog2(CLKS_PER_BIT);

  logic            rx_meta_r;
  logic            rx_sync_r;
  rx_state_t       state_r;
  logic [TW-1:0]   timer_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            timer_half_s;
  logic            timer_full_s;

  assign timer_half_s = (timer_r == TW'(HALF_BIT - 1));
  assign timer_full_s = (timer_r == TW'(CLKS_PER_BIT - 1));

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM with bit timer; the start bit is re-checked at mid-bit to reject glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= RX_IDLE;
      timer_r         <= {TW{1'b0}};
      bit_cnt_r       <= 3'd0;
      shift_r         <= 8'h00;
      data            <= 8'h00;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          timer_r   <= {TW{1'b0}};
          bit_cnt_r <= 3'd0;
          if (!rx_sync_r) state_r <= RX_START;
        end
        RX_START: begin
          if (timer_half_s) begin
            timer_r <= {TW{1'b0}};
            state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RX_DATA: begin
          if (timer_full_s) begin
            timer_r   <= {TW{1'b0}};
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) state_r <= RX_STOP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RX_STOP: begin
          if (timer_full_s) begin
            timer_r <= {TW{1'b0}};
            if (rx_sync_r) begin
              data       <= shift_r;
              byte_valid <= 1'b1;
              state_r    <= RX_IDLE;
            end else begin
              frame_err_pulse <= 1'b1;
              state_r         <= RX_WAIT_IDLE;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_sync_r) state_r <= RX_IDLE;
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tm_serial_loader.sv
// UART command front end for the Turing machine core: buffers one received byte and
// replays it as a clean input_data/Next/Done pulse with fixed setup, width and gap.
module tm_serial_loader
  import tm_loader_pkg::*;
#(
  parameter int AW           = 6,
  parameter int CLKS_PER_BIT = 87,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  tm_serial_loader_if.master    core,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  cmd_err
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [7:0]             rx_data_s;
  logic                   rx_valid_s;
  logic                   rx_ferr_s;
  logic [7:0]             buf_data_r;
  logic                   buf_full_r;
  logic                   buf_full_next_s;
  logic                   buf_load_s;
  logic                   drop_s;
  logic                   pop_s;
  opcode_t                op_s;
  logic [CMD_VALUE_W-1:0] value_s;
  seq_state_t             seq_state_r;
  seq_state_t             seq_next_s;
  logic [CW-1:0]          cnt_r;
  logic                   sel_done_r;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock           (clock),
    .reset           (reset),
    .rx              (rx),
    .data            (rx_data_s),
    .byte_valid      (rx_valid_s),
    .frame_err_pulse (rx_ferr_s)
  );

  // Buffer bookkeeping and sequencer next state; a pop frees the slot for a same-cycle byte.
  always_comb begin
    op_s       = cmd_opcode(buf_data_r);
    value_s    = cmd_value(buf_data_r);
    pop_s      = (seq_state_r == SEQ_IDLE) && buf_full_r;
    buf_load_s = rx_valid_s && (!buf_full_r || pop_s);
    drop_s     = rx_valid_s && buf_full_r && !pop_s;
    if (rx_valid_s) begin
      buf_full_next_s = 1'b1;
    end else if (pop_s) begin
      buf_full_next_s = 1'b0;
    end else begin
      buf_full_next_s = buf_full_r;
    end
    seq_next_s = seq_state_r;
    case (seq_state_r)
      SEQ_IDLE: begin
        if (pop_s && (op_s != OP_RSVD)) seq_next_s = SEQ_SETUP;
        else seq_next_s = SEQ_IDLE;
      end
      SEQ_SETUP: seq_next_s = SEQ_PULSE;
      SEQ_PULSE: begin
        if (cnt_r == {CW{1'b0}}) seq_next_s = SEQ_GAP;
        else seq_next_s = SEQ_PULSE;
      end
      SEQ_GAP: begin
        if (cnt_r == {CW{1'b0}}) seq_next_s = SEQ_IDLE;
        else seq_next_s = SEQ_GAP;
      end
      default: seq_next_s = SEQ_IDLE;
    endcase
  end

  // Registered state, buffer, sticky flags and core-facing outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq_state_r     <= SEQ_IDLE;
      buf_full_r      <= 1'b0;
      buf_data_r      <= 8'h00;
      cnt_r           <= {CW{1'b0}};
      sel_done_r      <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      frame_err       <= 1'b0;
      cmd_err         <= 1'b0;
      core.input_data <= {AW{1'b0}};
      core.Next       <= 1'b0;
      core.Done       <= 1'b0;
    end else begin
      seq_state_r <= seq_next_s;
      buf_full_r  <= buf_full_next_s;
      if (buf_load_s) buf_data_r <= rx_data_s;
      busy      <= (seq_next_s != SEQ_IDLE) || buf_full_next_s;
      overrun   <= overrun | drop_s;
      frame_err <= frame_err | rx_ferr_s;
      cmd_err   <= cmd_err | (pop_s && (op_s == OP_RSVD));
      case (seq_state_r)
        SEQ_IDLE: begin
          if (pop_s && (op_s != OP_RSVD)) begin
            sel_done_r <= (op_s == OP_DONE);
            if (op_s == OP_DATA) core.input_data <= value_s[AW-1:0];
          end
        end
        SEQ_SETUP: begin
          cnt_r <= CW'(PULSE_CYCLES - 1);
          if (sel_done_r) core.Done <= 1'b1;
          else core.Next <= 1'b1;
        end
        SEQ_PULSE: begin
          if (cnt_r == {CW{1'b0}}) begin
            core.Next <= 1'b0;
            core.Done <= 1'b0;
            cnt_r     <= CW'(GAP_CYCLES - 1);
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        SEQ_GAP: begin
          if (cnt_r != {CW{1'b0}}) cnt_r <= cnt_r - CW'(1);
        end
        default: begin
          core.Next <= 1'b0;
          core.Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm_serial_loader.sv
// Directed bench for tm_serial_loader: UART bytes in, Next/Done pulses logged and checked.
module tb_tm_serial_loader;

  localparam int CPB     = 8;
  localparam int PULSE   = 2;
  localparam int GAP     = 2;
  localparam int AW      = 6;
  // A long pulse lets the second instance be busy across two byte times, so a third byte overruns.
  localparam int PULSE_B = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;
  logic busy_a, overrun_a, frame_err_a, cmd_err_a;
  logic busy_b, overrun_b, frame_err_b, cmd_err_b;

  tm_serial_loader_if #(.AW(AW)) core_a ();
  tm_serial_loader_if #(.AW(AW)) core_b ();

  always #5 clock = ~clock;

  tm_serial_loader #(.AW(AW), .CLKS_PER_BIT(CPB), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_a), .core(core_a),
    .busy(busy_a), .overrun(overrun_a), .frame_err(frame_err_a), .cmd_err(cmd_err_a)
  );

  tm_serial_loader #(.AW(AW), .CLKS_PER_BIT(CPB), .PULSE_CYCLES(PULSE_B), .GAP_CYCLES(GAP)) dut_b (
    .clock(clock), .reset(reset), .rx(rx_b), .core(core_b),
    .busy(busy_b), .overrun(overrun_b), .frame_err(frame_err_b), .cmd_err(cmd_err_b)
  );

  typedef struct {
    logic is_done;
    int   data;
    int   pre_data;
    int   width;
    int   low_before;
    logic unstable;
  } pulse_t;

  pulse_t log_a[$];
  pulse_t cur_a;
  int     rise_b_data[$];
  int     rise_b_low[$];
  logic   both_high_seen = 1'b0;
  int     tail_busy = 0;
  logic   any_busy;
  int     n_asserts = 0;
  int     n_fail = 0;

  initial begin : mon_a
    int   low_cnt;
    int   prev_data;
    logic prev_hi;
    logic tail_open;
    low_cnt = 0; prev_data = 0; prev_hi = 1'b0; tail_open = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_hi = 1'b0; low_cnt = 0; tail_open = 1'b0;
      end else begin
        if (core_a.Next && core_a.Done) both_high_seen = 1'b1;
        if (core_a.Next || core_a.Done) begin
          if (!prev_hi) begin
            cur_a.is_done    = core_a.Done;
            cur_a.data       = int'(core_a.input_data);
            cur_a.pre_data   = prev_data;
            cur_a.width      = 0;
            cur_a.low_before = low_cnt;
            cur_a.unstable   = 1'b0;
          end
          cur_a.width = cur_a.width + 1;
          if (int'(core_a.input_data) != cur_a.data) cur_a.unstable = 1'b1;
          low_cnt = 0;
          prev_hi = 1'b1;
        end else begin
          if (prev_hi) begin
            log_a.push_back(cur_a);
            tail_busy = 0;
            tail_open = 1'b1;
          end
          if (tail_open) begin
            if (busy_a) tail_busy = tail_busy + 1;
            else tail_open = 1'b0;
          end
          prev_hi = 1'b0;
          low_cnt = low_cnt + 1;
        end
        prev_data = int'(core_a.input_data);
      end
    end
  end

  initial begin : mon_b
    int   low_cnt;
    logic prev_hi;
    low_cnt = 0; prev_hi = 1'b0;
    forever begin
      @(negedge clock);
      if (core_b.Next || core_b.Done) begin
        if (!prev_hi) begin
          rise_b_data.push_back(int'(core_b.input_data));
          rise_b_low.push_back(low_cnt);
        end
        prev_hi = 1'b1;
        low_cnt = 0;
      end else begin
        prev_hi = 1'b0;
        low_cnt = low_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts = n_asserts + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic to_b);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (to_b) rx_b = frame[i];
      else rx_a = frame[i];
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic wait_log_a(input int n, input string tag);
    int k;
    k = 0;
    while ((log_a.size() < n) && (k < 400)) begin
      @(negedge clock);
      k = k + 1;
    end
    chk({tag, "_arrived"}, 32'(log_a.size() >= n), 32'd1);
  endtask

  task automatic wait_idle_a(input string tag);
    int k;
    k = 0;
    while (busy_a && (k < 400)) begin
      @(negedge clock);
      k = k + 1;
    end
    chk({tag, "_busy_clear"}, 32'(busy_a), 32'd0);
  endtask

  task automatic check_pulse(input int idx, input logic is_done, input int data, input string tag);
    if (log_a.size() > idx) begin
      chk({tag, "_kind"},     32'(log_a[idx].is_done),  32'(is_done));
      chk({tag, "_data"},     32'(log_a[idx].data),     32'(data));
      chk({tag, "_pre_data"}, 32'(log_a[idx].pre_data), 32'(data));
      chk({tag, "_width"},    32'(log_a[idx].width),    32'(PULSE));
      chk({tag, "_stable"},   32'(log_a[idx].unstable), 32'd0);
    end else begin
      chk({tag, "_present"}, 32'(log_a.size()), 32'(idx + 1));
    end
  endtask

  initial begin : stim
    int k;
    repeat (3) @(negedge clock);
    chk("rst_in_next",  32'(core_a.Next), 32'd0);
    chk("rst_in_done",  32'(core_a.Done), 32'd0);
    chk("rst_in_data",  32'(core_a.input_data), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_busy",     32'(busy_a), 32'd0);
    chk("rst_flags",    32'({overrun_a, frame_err_a, cmd_err_a}), 32'd0);
    chk("rst_data",     32'(core_a.input_data), 32'd0);

    // 1: DATA 5
    send_byte(8'h05, 1'b1, 1'b0);
    wait_log_a(1, "t1");
    check_pulse(0, 1'b0, 5, "t1_next");
    wait_idle_a("t1");
    chk("t1_gap_len", 32'(tail_busy), 32'(GAP));
    chk("t1_flags",   32'({overrun_a, frame_err_a, cmd_err_a}), 32'd0);

    // 2: DONE then STEP, data held
    send_byte(8'h40, 1'b1, 1'b0);
    wait_log_a(2, "t2a");
    check_pulse(1, 1'b1, 5, "t2_done");
    send_byte(8'h80, 1'b1, 1'b0);
    wait_log_a(3, "t2b");
    check_pulse(2, 1'b0, 5, "t2_step");
    wait_idle_a("t2");
    chk("t2_data_held", 32'(core_a.input_data), 32'd5);
    chk("t2_exclusive", 32'(both_high_seen), 32'd0);

    // 3: back-to-back bytes into the long-pulse instance
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);
    send_byte(8'h03, 1'b1, 1'b1);
    k = 0;
    while (((rise_b_data.size() < 2) || busy_b) && (k < 1500)) begin
      @(negedge clock);
      k = k + 1;
    end
    chk("t3_pulse_count", 32'(rise_b_data.size()), 32'd2);
    if (rise_b_data.size() >= 2) begin
      chk("t3_data0", 32'(rise_b_data[0]), 32'd1);
      chk("t3_data1", 32'(rise_b_data[1]), 32'd2);
      chk("t3_spacing_ok", 32'(rise_b_low[1] >= GAP + 1), 32'd1);
    end
    chk("t3_overrun",    32'(overrun_b), 32'd1);
    chk("t3_other_flags", 32'({frame_err_b, cmd_err_b}), 32'd0);
    chk("t3_a_overrun",  32'(overrun_a), 32'd0);

    // 4: framing error, line held low, then recovery
    send_byte(8'h2A, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    rx_a = 1'b1;
    repeat (12) @(negedge clock);
    chk("t4_frame_err", 32'(frame_err_a), 32'd1);
    chk("t4_no_pulse",  32'(log_a.size()), 32'd3);
    chk("t4_busy",      32'(busy_a), 32'd0);
    send_byte(8'h07, 1'b1, 1'b0);
    wait_log_a(4, "t4");
    check_pulse(3, 1'b0, 7, "t4_next");
    wait_idle_a("t4");

    // 5: false start glitch, then reserved opcode
    any_busy = 1'b0;
    rx_a = 1'b0;
    repeat (3) @(negedge clock);
    rx_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy_a) any_busy = 1'b1;
    end
    chk("t5_glitch_busy",   32'(any_busy), 32'd0);
    chk("t5_glitch_nopulse", 32'(log_a.size()), 32'd4);
    chk("t5_glitch_flags",  32'({overrun_a, cmd_err_a}), 32'd0);
    send_byte(8'hC9, 1'b1, 1'b0);
    repeat (20) @(negedge clock);
    chk("t5_cmd_err",  32'(cmd_err_a), 32'd1);
    chk("t5_no_pulse", 32'(log_a.size()), 32'd4);
    chk("t5_data",     32'(core_a.input_data), 32'd7);
    chk("t5_busy",     32'(busy_a), 32'd0);

    // 6: reset during a pulse
    send_byte(8'h03, 1'b1, 1'b0);
    k = 0;
    while (!core_a.Next && (k < 100)) begin
      @(negedge clock);
      k = k + 1;
    end
    chk("t6_saw_next", 32'(core_a.Next), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_next_drop", 32'(core_a.Next), 32'd0);
    chk("t6_done_low",  32'(core_a.Done), 32'd0);
    chk("t6_data_zero", 32'(core_a.input_data), 32'd0);
    chk("t6_flags",     32'({busy_a, overrun_a, frame_err_a, cmd_err_a}), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    log_a.delete();
    repeat (5) @(negedge clock);
    send_byte(8'h11, 1'b1, 1'b0);
    wait_log_a(1, "t6");
    check_pulse(0, 1'b0, 17, "t6_next");
    wait_idle_a("t6");
    chk("end_exclusive", 32'(both_high_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
